// File: rtl/pe_core_pkg.sv
// Shared constants and FSM encoding for the PE core sequencer.
package pe_core_pkg;

  localparam int unsigned DefaultRows    = 32;
  localparam int unsigned DefaultCols    = 32;
  localparam int unsigned DefaultPostLat = 3;
  localparam int unsigned DefaultNMux    = 4;
  localparam int unsigned DefaultOaw     = 6;
  localparam int unsigned DefaultCntW    = 16;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StLoad    = 2'd1,
    StCompute = 2'd2,
    StDrain   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/pe_core_sequencer_if.sv
// Configuration, control and status bundle between a job controller and the sequencer.
interface pe_core_sequencer_if import pe_core_pkg::*; #(
  parameter int unsigned N_MUX = DefaultNMux,
  parameter int unsigned OAW   = DefaultOaw,
  parameter int unsigned CNT_W = DefaultCntW
);

  logic                   cfg_valid;
  logic                   cfg_ready;
  logic [CNT_W-1:0]       cfg_n_vec;
  logic [N_MUX-1:0]       cfg_outlier_sel;
  logic [N_MUX*OAW-1:0]   cfg_outlier_addr;
  logic                   abort;
  logic                   w_valid_lo;
  logic                   w_valid_hi;
  logic                   act_valid;

  logic                   load_weight_en;
  logic [N_MUX-1:0]       outlier_sel;
  logic [N_MUX*OAW-1:0]   outlier_addr;
  logic                   array_out_valid;
  logic                   post_valid;
  logic                   res_start;
  logic                   busy;
  logic                   done;
  logic                   err_ovr;

  modport master (
    output cfg_valid, cfg_n_vec, cfg_outlier_sel, cfg_outlier_addr, abort,
           w_valid_lo, w_valid_hi, act_valid,
    input  cfg_ready, load_weight_en, outlier_sel, outlier_addr, array_out_valid,
           post_valid, res_start, busy, done, err_ovr
  );

  modport slave (
    input  cfg_valid, cfg_n_vec, cfg_outlier_sel, cfg_outlier_addr, abort,
           w_valid_lo, w_valid_hi, act_valid,
    output cfg_ready, load_weight_en, outlier_sel, outlier_addr, array_out_valid,
           post_valid, res_start, busy, done, err_ovr
  );

endinterface

// File: rtl/valid_delay_line.sv
// Fixed-depth valid shift register with synchronous flush; DEPTH must be at least 1.
module valid_delay_line #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush_i,
  input  logic valid_i,
  output logic valid_o,
  output logic busy_o
);

  logic [DEPTH-1:0] sr_q;

  // Shift one stage per cycle; flush wins over new input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else if (flush_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= (sr_q << 1) | DEPTH'(valid_i);
    end
  end

  assign valid_o = sr_q[DEPTH-1];
  assign busy_o  = |sr_q;

endmodule

// File: rtl/pe_core_sequencer.sv
// Job sequencer for the systolic PE core: weight load, activation streaming, drain.
module pe_core_sequencer import pe_core_pkg::*; #(
  parameter int unsigned ROWS     = DefaultRows,
  parameter int unsigned COLS     = DefaultCols,
  parameter int unsigned POST_LAT = DefaultPostLat,
  parameter int unsigned N_MUX    = DefaultNMux,
  parameter int unsigned OAW      = DefaultOaw,
  parameter int unsigned CNT_W    = DefaultCntW
) (
  input logic                clk,
  input logic                rst_n,
  pe_core_sequencer_if.slave seq_if
);

  localparam int unsigned RowCntW  = $clog2(ROWS + 1);
  localparam int unsigned TailCntW = $clog2(COLS + 1);

  seq_state_e           state_q;
  logic [RowCntW-1:0]   load_cnt_q;
  logic [CNT_W-1:0]     act_cnt_q;
  logic [TailCntW-1:0]  tail_cnt_q;
  logic [CNT_W-1:0]     n_vec_q;
  logic [N_MUX-1:0]     outlier_sel_q;
  logic [N_MUX*OAW-1:0] outlier_addr_q;
  logic                 res_start_q;
  logic                 err_ovr_q;
  logic [1:0]           w_pipe_q;

  logic w_valid;
  logic kill;
  logic accept;
  logic load_en;
  logic act_acc;
  logic array_valid;
  logic array_busy;
  logic post_valid;
  logic post_busy;
  logic lines_empty;
  logic done;

  assign w_valid     = seq_if.w_valid_lo | seq_if.w_valid_hi;
  // Abort only acts on a running job.
  assign kill        = seq_if.abort && (state_q != StIdle);
  assign accept      = seq_if.cfg_valid && (state_q == StIdle);
  assign load_en     = w_pipe_q[1] && (state_q == StLoad);
  assign act_acc     = seq_if.act_valid && (state_q == StCompute);
  assign lines_empty = !array_busy && !post_busy;
  assign done        = (state_q == StDrain) && lines_empty &&
                       (tail_cnt_q == TailCntW'(COLS - 1)) && !seq_if.abort;

  // Two-cycle weight-valid pipeline matching the bank read-to-array latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_pipe_q <= '0;
    end else if (kill) begin
      w_pipe_q <= '0;
    end else begin
      w_pipe_q <= {w_pipe_q[0], w_valid};
    end
  end

  // Main job FSM with its counters, shadow config and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      load_cnt_q     <= '0;
      act_cnt_q      <= '0;
      tail_cnt_q     <= '0;
      n_vec_q        <= '0;
      outlier_sel_q  <= '0;
      outlier_addr_q <= '0;
      res_start_q    <= 1'b0;
      err_ovr_q      <= 1'b0;
    end else begin
      res_start_q <= 1'b0;
      // A stray activation is reported even if a new job is accepted in the same cycle.
      if (seq_if.act_valid && (state_q != StCompute)) begin
        err_ovr_q <= 1'b1;
      end else if (accept) begin
        err_ovr_q <= 1'b0;
      end

      if (kill) begin
        state_q    <= StIdle;
        load_cnt_q <= '0;
        act_cnt_q  <= '0;
        tail_cnt_q <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (accept) begin
              n_vec_q        <= (seq_if.cfg_n_vec == '0) ? CNT_W'(1) : seq_if.cfg_n_vec;
              outlier_sel_q  <= seq_if.cfg_outlier_sel;
              outlier_addr_q <= seq_if.cfg_outlier_addr;
              res_start_q    <= 1'b1;
              load_cnt_q     <= '0;
              act_cnt_q      <= '0;
              tail_cnt_q     <= '0;
              state_q        <= StLoad;
            end
          end
          StLoad: begin
            if (load_en) begin
              if (load_cnt_q == RowCntW'(ROWS - 1)) begin
                load_cnt_q <= '0;
                state_q    <= StCompute;
              end else begin
                load_cnt_q <= load_cnt_q + 1'b1;
              end
            end
          end
          StCompute: begin
            if (act_acc) begin
              if (act_cnt_q == n_vec_q - CNT_W'(1)) begin
                act_cnt_q <= '0;
                state_q   <= StDrain;
              end else begin
                act_cnt_q <= act_cnt_q + 1'b1;
              end
            end
          end
          StDrain: begin
            // Tail counts consecutive empty cycles to cover the output de-skew.
            if (!lines_empty) begin
              tail_cnt_q <= '0;
            end else if (tail_cnt_q == TailCntW'(COLS - 1)) begin
              tail_cnt_q <= '0;
              state_q    <= StIdle;
            end else begin
              tail_cnt_q <= tail_cnt_q + 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // Array traversal: flushed while new weights shift in so stale data never escapes.
  valid_delay_line #(
    .DEPTH (ROWS)
  ) u_array_dly (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (load_en | kill),
    .valid_i (act_acc),
    .valid_o (array_valid),
    .busy_o  (array_busy)
  );

  valid_delay_line #(
    .DEPTH (POST_LAT)
  ) u_post_dly (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (kill),
    .valid_i (array_valid),
    .valid_o (post_valid),
    .busy_o  (post_busy)
  );

  assign seq_if.cfg_ready       = (state_q == StIdle);
  assign seq_if.busy            = (state_q != StIdle);
  assign seq_if.load_weight_en  = load_en;
  assign seq_if.outlier_sel     = outlier_sel_q;
  assign seq_if.outlier_addr    = outlier_addr_q;
  assign seq_if.array_out_valid = array_valid;
  assign seq_if.post_valid      = post_valid;
  assign seq_if.res_start       = res_start_q;
  assign seq_if.done            = done;
  assign seq_if.err_ovr         = err_ovr_q;

endmodule

// File: tb/tb_pe_core_sequencer.sv
// Directed bench: default build (A) plus a ROWS=8/COLS=8/POST_LAT=1 build (B).
module tb_pe_core_sequencer;

  localparam int unsigned NMux = 4;
  localparam int unsigned Oaw  = 6;
  localparam int unsigned CntW = 16;

  typedef struct {
    logic [15:0] n_vec;
    logic [3:0]  sel;
    logic [23:0] addr;
    int          n_act;
    int          gap;
    int          exp_aov_n;
    int          exp_aov_ofs;
    int          exp_pv_ofs;
    int          exp_done_ofs;
  } job_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pe_core_sequencer_if #(.N_MUX(NMux), .OAW(Oaw), .CNT_W(CntW)) bus_a ();
  pe_core_sequencer_if #(.N_MUX(NMux), .OAW(Oaw), .CNT_W(CntW)) bus_b ();

  pe_core_sequencer #(
    .N_MUX (NMux),
    .OAW   (Oaw),
    .CNT_W (CntW)
  ) u_dut_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .seq_if (bus_a)
  );

  pe_core_sequencer #(
    .ROWS     (8),
    .COLS     (8),
    .POST_LAT (1),
    .N_MUX    (NMux),
    .OAW      (Oaw),
    .CNT_W    (CntW)
  ) u_dut_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .seq_if (bus_b)
  );

  int cyc;
  int n_tests;
  int n_fail;
  int aov_n, aov_first, pv_n, pv_first, done_n, done_first, lwe_n, lwe_first;
  int b_aov_first, b_pv_first, b_done_n, b_done_first;
  int ready_bad;
  job_t jobs[4];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic clear_mon();
    aov_n = 0; aov_first = -1; pv_n = 0; pv_first = -1;
    done_n = 0; done_first = -1; lwe_n = 0; lwe_first = -1;
    b_aov_first = -1; b_pv_first = -1; b_done_n = 0; b_done_first = -1;
    ready_bad = 0;
  endtask

  // Sample outputs of the current cycle at the falling edge, then advance one cycle.
  task automatic step();
    @(negedge clk);
    if (bus_a.array_out_valid) begin if (aov_n == 0) aov_first = cyc; aov_n++; end
    if (bus_a.post_valid) begin if (pv_n == 0) pv_first = cyc; pv_n++; end
    if (bus_a.done) begin if (done_n == 0) done_first = cyc; done_n++; end
    if (bus_a.load_weight_en) begin if (lwe_n == 0) lwe_first = cyc; lwe_n++; end
    if (bus_a.busy && bus_a.cfg_ready) ready_bad++;
    if (bus_b.array_out_valid && b_aov_first < 0) b_aov_first = cyc;
    if (bus_b.post_valid && b_pv_first < 0) b_pv_first = cyc;
    if (bus_b.done) begin if (b_done_n == 0) b_done_first = cyc; b_done_n++; end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic cfg_a(input logic [15:0] n, input logic [3:0] s, input logic [23:0] a);
    bus_a.cfg_valid = 1'b1; bus_a.cfg_n_vec = n;
    bus_a.cfg_outlier_sel = s; bus_a.cfg_outlier_addr = a;
    step();
    bus_a.cfg_valid = 1'b0;
  endtask

  // 32 weight-valid cycles (alternating banks) plus the two-cycle pipeline tail.
  task automatic load_a();
    for (int i = 0; i < 32; i++) begin
      bus_a.w_valid_lo = (i % 2 == 0); bus_a.w_valid_hi = (i % 2 == 1);
      step();
    end
    bus_a.w_valid_lo = 1'b0; bus_a.w_valid_hi = 1'b0;
    step(); step();
  endtask

  task automatic abort_a();
    bus_a.abort = 1'b1; step(); bus_a.abort = 1'b0;
  endtask

  task automatic run_job(input int idx, input job_t j);
    int w0, a_first, a_last, t;
    string tag;
    tag = $sformatf("job%0d", idx);
    clear_mon();
    check({tag, "_cfg_ready"}, bus_a.cfg_ready, 1);
    cfg_a(j.n_vec, j.sel, j.addr);
    check({tag, "_outlier_sel"}, bus_a.outlier_sel, j.sel);
    check({tag, "_outlier_addr"}, bus_a.outlier_addr, j.addr);
    check({tag, "_res_start"}, bus_a.res_start, 1);
    check({tag, "_busy"}, bus_a.busy, 1);
    w0 = cyc;
    load_a();
    check({tag, "_lwe_count"}, lwe_n, 32);
    check({tag, "_lwe_latency"}, lwe_first - w0, 2);
    a_first = cyc; a_last = cyc;
    for (int i = 0; i < j.n_act; i++) begin
      bus_a.act_valid = 1'b1; a_last = cyc; step(); bus_a.act_valid = 1'b0;
      for (int g = 0; g < j.gap; g++) step();
    end
    t = 0;
    while (done_n == 0 && t < 300) begin step(); t++; end
    for (int i = 0; i < 5; i++) step();
    check({tag, "_aov_count"}, aov_n, j.exp_aov_n);
    check({tag, "_aov_latency"}, aov_first - a_first, j.exp_aov_ofs);
    check({tag, "_pv_count"}, pv_n, j.exp_aov_n);
    check({tag, "_pv_latency"}, pv_first - a_first, j.exp_pv_ofs);
    check({tag, "_done_count"}, done_n, 1);
    check({tag, "_done_time"}, done_first - a_last, j.exp_done_ofs);
    check({tag, "_err_ovr"}, bus_a.err_ovr, 0);
    check({tag, "_busy_end"}, bus_a.busy, 0);
  endtask

  initial begin
    int t, a;
    cyc = 0; n_tests = 0; n_fail = 0;
    clear_mon();
    bus_a.cfg_valid = 0; bus_a.cfg_n_vec = '0; bus_a.cfg_outlier_sel = '0;
    bus_a.cfg_outlier_addr = '0; bus_a.abort = 0; bus_a.w_valid_lo = 0;
    bus_a.w_valid_hi = 0; bus_a.act_valid = 0;
    bus_b.cfg_valid = 0; bus_b.cfg_n_vec = '0; bus_b.cfg_outlier_sel = '0;
    bus_b.cfg_outlier_addr = '0; bus_b.abort = 0; bus_b.w_valid_lo = 0;
    bus_b.w_valid_hi = 0; bus_b.act_valid = 0;

    // Latency offsets: array 32 after act, post 3 more, done 32 after last post_valid.
    jobs[0] = '{16'd4, 4'b1001, 24'hE40015, 4, 0, 4, 32, 35, 67};
    jobs[1] = '{16'd0, 4'b0110, 24'h123456, 1, 0, 1, 32, 35, 67};
    jobs[2] = '{16'd3, 4'b1111, 24'hFFFFFF, 3, 2, 3, 32, 35, 67};
    jobs[3] = '{16'd2, 4'b1000, 24'h03F0C1, 2, 1, 2, 32, 35, 67};

    rst_n = 1'b0;
    step(); step();
    check("rst_busy", bus_a.busy, 0);
    check("rst_outlier_sel", bus_a.outlier_sel, 0);
    check("rst_outlier_addr", bus_a.outlier_addr, 0);
    check("rst_flags", {bus_a.load_weight_en, bus_a.array_out_valid, bus_a.post_valid,
                        bus_a.res_start, bus_a.done, bus_a.err_ovr}, 6'b0);
    rst_n = 1'b1;
    step();
    check("rst_cfg_ready", bus_a.cfg_ready, 1);

    for (int i = 0; i < 4; i++) run_job(i, jobs[i]);

    // Abort in COMPUTE after 2 of 8 vectors.
    clear_mon();
    cfg_a(16'd8, 4'b0001, 24'h000001);
    load_a();
    bus_a.act_valid = 1'b1; step(); step(); bus_a.act_valid = 1'b0;
    step(); step();
    abort_a();
    check("abort_busy", bus_a.busy, 0);
    check("abort_cfg_ready", bus_a.cfg_ready, 1);
    for (int i = 0; i < 60; i++) step();
    check("abort_no_aov", aov_n, 0);
    check("abort_no_pv", pv_n, 0);
    check("abort_no_done", done_n, 0);
    // Abort in IDLE must not block a configuration in the same cycle.
    bus_a.abort = 1'b1;
    cfg_a(16'd1, 4'b0010, 24'h0000AA);
    bus_a.abort = 1'b0;
    check("idle_abort_ignored", bus_a.busy, 1);
    abort_a();

    // Activation during LOAD: overrun flag, nothing enters the array.
    clear_mon();
    cfg_a(16'd1, 4'b0100, 24'h00BEEF);
    bus_a.act_valid = 1'b1; step(); bus_a.act_valid = 1'b0;
    check("ovr_set", bus_a.err_ovr, 1);
    for (int i = 0; i < 40; i++) step();
    check("ovr_no_aov", aov_n, 0);
    abort_a();
    check("ovr_sticky", bus_a.err_ovr, 1);
    cfg_a(16'd1, 4'b0100, 24'h00BEEF);
    check("ovr_cleared", bus_a.err_ovr, 0);
    abort_a();

    // cfg_valid held through a job: second config waits for IDLE.
    clear_mon();
    cfg_a(16'd1, 4'b0011, 24'h111111);
    bus_a.cfg_valid = 1'b1; bus_a.cfg_outlier_sel = 4'b0101;
    bus_a.cfg_outlier_addr = 24'h2A2A2A;
    load_a();
    bus_a.act_valid = 1'b1; step(); bus_a.act_valid = 1'b0;
    t = 0;
    while (done_n == 0 && t < 300) begin step(); t++; end
    check("hold_done_seen", done_n, 1);
    check("hold_ready_after_done", bus_a.cfg_ready, 1);
    check("hold_not_overwritten", bus_a.outlier_addr, 24'h111111);
    check("hold_ready_low_while_busy", ready_bad, 0);
    step();
    bus_a.cfg_valid = 1'b0;
    check("hold_accepted_sel", bus_a.outlier_sel, 4'b0101);
    check("hold_accepted_res_start", bus_a.res_start, 1);
    check("hold_accepted_busy", bus_a.busy, 1);
    abort_a();

    // Reset asserted mid-job abandons it silently.
    clear_mon();
    cfg_a(16'd1, 4'b1110, 24'h777777);
    load_a();
    bus_a.act_valid = 1'b1; step(); bus_a.act_valid = 1'b0;
    step(); step();
    rst_n = 1'b0;
    step();
    check("midrst_busy", bus_a.busy, 0);
    check("midrst_outlier_sel", bus_a.outlier_sel, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) step();
    check("midrst_no_done", done_n, 0);
    check("midrst_no_aov", aov_n, 0);

    // Small build: post_valid 9 cycles after act, done after a 7-cycle tail.
    clear_mon();
    bus_b.cfg_valid = 1'b1; bus_b.cfg_n_vec = 16'd1; step(); bus_b.cfg_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin bus_b.w_valid_hi = 1'b1; step(); end
    bus_b.w_valid_hi = 1'b0;
    step(); step();
    a = cyc;
    bus_b.act_valid = 1'b1; step(); bus_b.act_valid = 1'b0;
    t = 0;
    while (b_done_n == 0 && t < 100) begin step(); t++; end
    step(); step(); step();
    check("small_aov_latency", b_aov_first - a, 8);
    check("small_pv_latency", b_pv_first - a, 9);
    check("small_done_time", b_done_first - a, 17);
    check("small_done_count", b_done_n, 1);
    check("small_busy_end", bus_b.busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_core_sequencer.md
PE_CORE_SEQUENCER -- requirements
Module: pe_core_sequencer

Interface
REQ-001 SHALL provide parameter ROWS, default 32, systolic array height and weight-load depth in vectors.
REQ-002 SHALL provide parameter COLS, default 32, array width and de-skew span.
REQ-003 SHALL provide parameter POST_LAT, default 3, post-process pipeline latency in cycles.
REQ-004 SHALL provide parameter N_MUX, default 4, number of outlier weight-mux groups.
REQ-005 SHALL provide parameter OAW, default 6, outlier address width per mux group.
REQ-006 SHALL provide parameter CNT_W, default 16, activation-vector counter width.
REQ-007 clk  input  1  clock; all logic rising-edge.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 cfg_valid / cfg_ready  input / output  1 / 1  configuration handshake.
REQ-010 cfg_n_vec  input  CNT_W  activation vectors per job; 0 is illegal.
REQ-011 cfg_outlier_sel / cfg_outlier_addr  input  N_MUX / N_MUX*OAW  outlier configuration.
REQ-012 abort  input  1  synchronous job cancel.
REQ-013 w_valid_lo, w_valid_hi  input  1 each  weight bank-pair read valids.
REQ-014 act_valid  input  1  activation vector valid at array row inputs.
REQ-015 load_weight_en  output  1  array weight-shift enable.
REQ-016 outlier_sel / outlier_addr  output  N_MUX / N_MUX*OAW  registered outlier configuration.
REQ-017 array_out_valid / post_valid  output  1 / 1  array-bottom valid / post-process output valid.
REQ-018 res_start  output  1  one-cycle pulse resetting write-back address counters.
REQ-019 busy, done, err_ovr  output  1 each  job active, one-cycle completion pulse, sticky overrun flag.

Function
REQ-020 SHALL implement FSM IDLE -> LOAD -> COMPUTE -> DRAIN -> IDLE.
REQ-021 IDLE: cfg_ready=1; cfg_valid&cfg_ready captures cfg_* into shadow registers, drives outlier_* from them next cycle, pulses res_start, enters LOAD.
REQ-022 w_valid = w_valid_lo|w_valid_hi; load_weight_en SHALL equal w_valid delayed exactly 2 cycles, gated to LOAD state only.
REQ-023 LOAD SHALL count load_weight_en cycles; on the ROWS-th, transition to COMPUTE the following cycle.
REQ-024 COMPUTE SHALL count act_valid cycles; on the cfg_n_vec-th, enter DRAIN.
REQ-025 act_valid outside COMPUTE SHALL be ignored and set err_ovr; err_ovr clears only on next accepted configuration.
REQ-026 array_out_valid SHALL equal act_valid (accepted only) delayed exactly ROWS cycles via a ROWS-bit shift register, flushed to 0 whenever load_weight_en=1.
REQ-027 post_valid SHALL equal array_out_valid delayed exactly POST_LAT cycles.
REQ-028 DRAIN SHALL wait until the delay lines are empty plus COLS-1 cycles (de-skew tail), then pulse done, and return to IDLE.
REQ-029 busy SHALL be 1 in LOAD, COMPUTE and DRAIN, 0 in IDLE.
REQ-030 abort in any non-IDLE state SHALL clear counters and delay lines and return to IDLE next cycle without pulsing done; abort in IDLE has no effect.
REQ-031 cfg_valid while busy SHALL be held off (cfg_ready=0), never dropped or overwritten.
REQ-032 Counters SHALL not wrap; cfg_n_vec=0 SHALL be treated as 1.

Reset
REQ-033 On rst_n low: state IDLE, all counters and shift registers 0, outlier_sel/addr 0, load_weight_en, array_out_valid, post_valid, res_start, done, busy, err_ovr 0; cfg_ready 1 after release.
REQ-034 Reset assertion mid-job SHALL abandon the job with no done pulse.

Structure
REQ-035 FSM state encoding and default ROWS/COLS/POST_LAT/N_MUX/OAW constants SHALL reside in shared package pe_core_pkg.
REQ-036 Fixed-depth valid delay line SHALL be one sub-module, valid_delay_line (parameter DEPTH, with synchronous flush), instantiated for ROWS and POST_LAT.

Verification
REQ-037 Config n_vec=4, sel=4'b1001, addr=24'hE40015; 32 w_valid cycles then 4 act_valid -> outlier outputs match next cycle, array_out_valid high 4 cycles starting 32 cycles after first act_valid, post_valid 3 cycles later, done once.
REQ-038 w_valid pulse at cycle T -> load_weight_en high at exactly T+2.
REQ-039 act_valid asserted during LOAD -> err_ovr=1, array_out_valid stays 0, sticky until next config.
REQ-040 abort during COMPUTE after 2 of 8 vectors -> busy=0 next cycle, no done, no further array_out_valid.
REQ-041 cfg_valid held during busy -> cfg_ready=0 until done, then accepted in IDLE the cycle after.
REQ-042 ROWS=8, COLS=8, POST_LAT=1 build, n_vec=1 -> post_valid exactly 9 cycles after act_valid, done after 7-cycle tail.
